// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: scan FSM states, matrix geometry and row
// priority helper used by the keypad scanner.
package board_io_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  // Lowest-index low row wins (row0 has highest priority).
  function automatic logic [1:0] first_low_row(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: tick is high for one clk every SCAN_DIV clks,
// while the count sits at SCAN_DIV-1.
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: rotates column drive, synchronizes rows and
// debounces press/release into a key code, a valid strobe and a held level.
//   state    | meaning
//   SCAN     | rotating columns, waiting for any row low
//   DEBOUNCE | column frozen, counting matching ticks before accepting press
//   PRESSED  | key accepted, waiting for all rows high
//   RELEASE  | counting all-high ticks before accepting release
module keypad_scanner
  import board_io_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CNT_W          = 17
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_COLS-1:0] col,
  input  logic [NUM_ROWS-1:0] row,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int DB_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  // Count holds (matching ticks - 1); the tick after DB_LAST completes the run.
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'((DEBOUNCE_SCANS >= 2) ? DEBOUNCE_SCANS - 2 : 0);

  logic                tick;
  scan_state_t         state_q;
  logic [NUM_ROWS-1:0] row_meta_q;
  logic [NUM_ROWS-1:0] row_s_q;
  logic [NUM_COLS-1:0] col_q;
  logic [1:0]          col_idx_q;
  logic [1:0]          row_idx_q;
  logic [DB_W-1:0]     db_cnt_q;
  logic [3:0]          key_code_q;
  logic                key_valid_q;
  logic                key_held_q;

  logic       key_present;
  logic [1:0] det_row;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign key_present = ~&row_s_q;
  assign det_row     = first_low_row(row_s_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      row_meta_q  <= '1;
      row_s_q     <= '1;
      col_q       <= COL_RESET;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      db_cnt_q    <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row;
      row_s_q     <= row_meta_q;
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (key_present) begin
              row_idx_q <= det_row;
              db_cnt_q  <= '0;
              if (DEBOUNCE_SCANS == 1) begin
                key_code_q  <= {det_row, col_idx_q};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                state_q     <= PRESSED;
              end else begin
                state_q <= DEBOUNCE;
              end
            end else begin
              col_q     <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (key_present && (det_row == row_idx_q)) begin
              if (db_cnt_q == DB_LAST) begin
                key_code_q  <= {row_idx_q, col_idx_q};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                state_q     <= PRESSED;
              end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
              end
            end else begin
              state_q   <= SCAN;
              col_q     <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          PRESSED: begin
            if (!key_present) begin
              db_cnt_q <= '0;
              if (DEBOUNCE_SCANS == 1) begin
                key_held_q <= 1'b0;
                state_q    <= SCAN;
                col_q      <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
                col_idx_q  <= col_idx_q + 2'd1;
              end else begin
                state_q <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (!key_present) begin
              if (db_cnt_q == DB_LAST) begin
                key_held_q <= 1'b0;
                state_q    <= SCAN;
                col_q      <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
                col_idx_q  <= col_idx_q + 2'd1;
              end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
              end
            end else begin
              db_cnt_q <= '0;
              state_q  <= PRESSED;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3; a
// behavioural key matrix pulls rows low for pressed keys in the driven column.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .CNT_W          (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input logic [15:0] k);
    @(negedge clk);
    reset = 1'b1;
    keys  = k;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col); end
    checks++;
    if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %h expected 0", key_code); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    checks++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
  endtask

  task automatic test_idle();
    logic [3:0] exp_col;
    int sh;
    do_reset(16'h0000);
    for (int i = 1; i <= 20; i++) begin
      step();
      sh = (i / 4) % 4;
      exp_col = ~(4'b0001 << sh);
      checks++;
      if (col !== exp_col) begin errors++; $display("FAIL idle_col cyc %0d: got %b expected %b", cyc, col, exp_col); end
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cyc %0d: got %b expected 0", cyc, key_valid); end
    end
    checks++;
    if (key_code !== 4'd0) begin errors++; $display("FAIL idle_code: got %h expected 0", key_code); end
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    int first  = -1;
    do_reset(16'h0040);             // row1, col2
    while (cyc < 40) begin
      step();
      if (key_valid) begin pulses++; if (first < 0) first = cyc; end
      // second key in the frozen column and a key in another column
      if (cyc == 30) keys = 16'h0040 | 16'h0004 | 16'h0080;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL press_pulses: got %0d expected 1", pulses); end
    checks++;
    if (first !== 20) begin errors++; $display("FAIL press_latency: got cyc %0d expected 20", first); end
    checks++;
    if (key_code !== 4'b0110) begin errors++; $display("FAIL press_code: got %b expected 0110", key_code); end
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b expected 1", key_held); end
    checks++;
    if (col !== 4'b1011) begin errors++; $display("FAIL press_col_frozen: got %b expected 1011", col); end
  endtask

  task automatic test_release();
    do_reset(16'h0040);
    step_to(40);
    keys = 16'h0000;
    step_to(51);
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL release_early: got held %b expected 1", key_held); end
    step();
    checks++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b expected 0", key_held); end
    checks++;
    if (col !== 4'b0111) begin errors++; $display("FAIL release_col: got %b expected 0111", col); end
    checks++;
    if (key_code !== 4'b0110) begin errors++; $display("FAIL release_code_kept: got %b expected 0110", key_code); end
    step_to(56);
    checks++;
    if (col !== 4'b1110) begin errors++; $display("FAIL release_rescan: got %b expected 1110", col); end
  endtask

  task automatic test_release_variant();
    int bad_held  = 0;
    int bad_valid = 0;
    do_reset(16'h0040);
    step_to(40);
    keys = 16'h0000;
    step_to(49);
    keys = 16'h0040;
    while (cyc < 70) begin
      step();
      if (key_held !== 1'b1) bad_held++;
      if (key_valid !== 1'b0) bad_valid++;
    end
    checks++;
    if (bad_held !== 0) begin errors++; $display("FAIL variant_held: got %0d low cycles expected 0", bad_held); end
    checks++;
    if (bad_valid !== 0) begin errors++; $display("FAIL variant_valid: got %0d pulses expected 0", bad_valid); end
    checks++;
    if (col !== 4'b1011) begin errors++; $display("FAIL variant_col: got %b expected 1011", col); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    do_reset(16'h0040);
    step_to(12);
    keys = 16'h0000;
    step_to(15);
    checks++;
    if (col !== 4'b1011) begin errors++; $display("FAIL bounce_frozen: got %b expected 1011", col); end
    step();
    checks++;
    if (col !== 4'b0111) begin errors++; $display("FAIL bounce_advance: got %b expected 0111", col); end
    while (cyc < 30) begin
      step();
      if (key_valid) pulses++;
      if (cyc == 20) begin
        checks++;
        if (col !== 4'b1110) begin errors++; $display("FAIL bounce_rescan: got %b expected 1110", col); end
      end
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL bounce_valid: got %0d pulses expected 0", pulses); end
    checks++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b expected 0", key_held); end
  endtask

  task automatic test_priority();
    int pulses = 0;
    int first  = -1;
    do_reset(16'h1100);             // rows 2 and 3 in col0
    while (cyc < 30) begin
      step();
      if (key_valid) begin pulses++; if (first < 0) first = cyc; end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL prio_pulses: got %0d expected 1", pulses); end
    checks++;
    if (first !== 12) begin errors++; $display("FAIL prio_latency: got cyc %0d expected 12", first); end
    checks++;
    if (key_code !== 4'b1000) begin errors++; $display("FAIL prio_code: got %b expected 1000", key_code); end
  endtask

  task automatic test_reset_mid_press();
    int pulses = 0;
    do_reset(16'h0040);
    step_to(25);
    checks++;
    if (key_held !== 1'b1) begin errors++; $display("FAIL midrst_pre_held: got %b expected 1", key_held); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (col !== 4'b1110) begin errors++; $display("FAIL midrst_col: got %b expected 1110", col); end
    checks++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL midrst_held: got %b expected 0", key_held); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", key_valid); end
    checks++;
    if (key_code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %h expected 0", key_code); end
    keys = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    while (cyc < 20) begin
      step();
      if (key_valid || key_held) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midrst_no_event: got %0d active cycles expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_clean_press();
    test_release();
    test_release_variant();
    test_bounce();
    test_priority();
    test_reset_mid_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 active-low key matrix and turns it into debounced key events. It is the input-side counterpart of the board's multiplexed display driver. Columns are driven one-hot-low in rotation, the same way digit anodes are, and the row lines are read back. A debounced key is reported as a 4-bit code with a one-cycle valid strobe and a held level, for the project's top-level control logic.

Parameters:
SCAN_DIV, 100000, clk cycles per scan tick (column dwell time); legal range >= 2
DEBOUNCE_SCANS, 4, consecutive scan ticks a key must hold a stable state before press or release is accepted; legal range >= 1
CNT_W, 17, prescaler width; must satisfy 2**CNT_W >= SCAN_DIV

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
col  out  4  column drive, active-low one-hot; col[i]=0 selects column i
row  in  4  row sense, active-low, asynchronous to clk (external pull-ups)
key_code  out  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key
key_valid  out  1  one-clk pulse when a press is accepted
key_held  out  1  high from accepted press until accepted release

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, prescaler=0, debounce count=0.
- row passes through a 2-flop synchronizer (row_s). All decisions use row_s only, which adds 2 clk of latency.
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick=1 for exactly one clk when the count equals SCAN_DIV-1. All FSM decisions below occur only on tick.
- A key is "present" when any bit of row_s is 0. The detected row is the lowest-index 0 bit (priority row0 > row3).
- States:
  - SCAN: on tick, if a key is present, latch the current column index and detected row, clear the debounce count and go to DEBOUNCE with the column frozen. Otherwise rotate col left: 1110->1101->1011->0111->1110.
  - DEBOUNCE: on tick, if the same row is still the detected row, increment the count. When the count reaches DEBOUNCE_SCANS-1 (DEBOUNCE_SCANS total matching ticks, including the detect tick), do all of: set key_code={row,col}, pulse key_valid for the next clk, set key_held=1, go to PRESSED. If there is no key or the row differs, return to SCAN and rotate to the next column on that tick.
  - PRESSED: column stays frozen. On tick, if row_s==4'b1111, clear the count and go to RELEASE. Otherwise remain.
  - RELEASE: on tick, if row_s==4'b1111, increment the count. After DEBOUNCE_SCANS consecutive high ticks, set key_held=0, go to SCAN and rotate col. If any row goes low first, return to PRESSED with the count cleared. key_valid does not re-pulse.
- A chatter-free press is accepted at tick (k + DEBOUNCE_SCANS - 1), where k is the detect tick; key_valid asserts one clk later.
- Multiple keys:
  - Several keys in the frozen column: the lowest row wins.
  - Keys in other columns are invisible while frozen.
  - A second key pressed in the same column while PRESSED does not generate an event.
- key_code holds its value until the next accepted press; it does not clear on release.
- When DEBOUNCE_SCANS=1, a press is accepted on the detect tick: SCAN goes directly to PRESSED.
- Reset mid-operation (any state): all outputs return to reset values on the asynchronous edge. No pending event survives reset.

Decomposition:
- Shared package (board_io_pkg):
  - scan state enum: SCAN, DEBOUNCE, PRESSED, RELEASE (2-bit)
  - NUM_COLS=4, NUM_ROWS=4
  - COL_RESET=4'b1110
- One sub-module, scan_tick_gen. It holds the SCAN_DIV prescaler with a single tick output and is reusable by the display driver's refresh rate.
- The synchronizer and FSM remain in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
- Idle:
  - Stimulus: release reset with row=4'b1111.
  - Response: col steps 1110,1101,1011,0111,1110 every 4 clk; key_valid never asserts; key_code=0.
- Clean press:
  - Stimulus: hold row1 low whenever col=1011 (col2), steady.
  - Response: column freezes at 1011; exactly one key_valid pulse 2 ticks after detect; key_code=4'b0110; key_held=1.
- Bounce reject:
  - Stimulus: row1 low for one tick in col2, then released.
  - Response: no key_valid; FSM returns to SCAN; col advances to 0111 on the same tick.
- Release:
  - Stimulus: after a clean press, set row=1111 for 3 ticks.
  - Response: key_held falls; scanning resumes at 0111.
  - Variant: row=1111 for 2 ticks then low again gives no key_held drop and no new key_valid.
- Priority:
  - Stimulus: in col0, rows 2 and 3 low simultaneously.
  - Response: key_code=4'b1000, single pulse.
- Reset mid-press:
  - Stimulus: assert reset while in PRESSED.
  - Response: immediately col=1110, key_held=0, key_valid=0, key_code=0.
